ddr_pixel_writer: RTL and testbench
===================================

Name: ddr_pixel_writer

Overview:
- Write-side client for the DDR controller; the counterpart of the existing readRequest/readData read path.
- Accepts per-pixel colour writes from the colour generator (GameOfLife or a successor) in the clk domain.
- Packs four 4-bit pixels into 16-bit words and queues them in a small FIFO.
- Presents the words to the DDR controller over a request/acknowledge write handshake.

Parameters:
DEPTH, 8, FIFO depth in 16-bit words; power of 2, minimum 2.
ADDR_WIDTH, 23, width of writeAddress; must be at least 17.

Ports:
clk  input  1  system clock (ClkGen clk output)
rst  input  1  asynchronous reset, active-low
pixelValid  input  1  pixel write strobe
pixelReady  output  1  pixel accepted this cycle when pixelValid && pixelReady
pixelRow  input  9  pixel row, 0..479
pixelColumn  input  10  pixel column, 0..639
pixelColor  input  3  pixel colour
flush  input  1  force the partial word into the FIFO
writeRequest  output  1  FIFO head valid
writeAck  input  1  DDR controller consumed the head word
writeAddress  output  ADDR_WIDTH  head word address
writeData  output  16  head word data
writeNibbleEn  output  4  per-nibble write enable of the head word
fifoLevel  output  log2(DEPTH)+1  words currently queued
dropped  output  1  sticky: a pixel was offered while pixelReady was low

Behaviour:
- Reset (rst low, async): FIFO empty, partial word invalid, flushPending=0, writeRequest=0, fifoLevel=0, dropped=0, writeAddress/writeData/writeNibbleEn=0.
- Word address = {pixelRow, pixelColumn[9:2]}, zero-extended to ADDR_WIDTH. Lane = pixelColumn[1:0].
- Lane placement: data bits [4*lane+3 : 4*lane] = {1'b0, pixelColor}.
- pixelReady (combinational) = (fifoLevel < DEPTH) && !flush && !flushPending.
- Accepted pixel, partial word invalid: start a new partial word at this address; write the lane; set only this lane's nibble enable.
- Accepted pixel, same address as the partial word: write the lane and OR in its enable. A rewrite of an already-set lane overwrites, last write wins.
- Accepted pixel, different address: push the old partial word (data and enables as held), then start a new partial word with the incoming pixel. This is one push in that cycle.
- Lane 3 written, same address: the completed word is pushed in the same cycle and the partial word becomes invalid.
- Lane 3 written, different address: the old word is pushed; the new partial word holds only lane 3 and stays partial. There is never more than one push per cycle.
- flush high:
  - partial valid and fifoLevel < DEPTH: push the partial word and invalidate it.
  - partial valid and FIFO full: set flushPending; the push occurs on the first cycle with space, then flushPending clears.
  - no partial word: no-op.
- Output side:
  - writeRequest = FIFO non-empty. writeAddress/writeData/writeNibbleEn show the head entry and hold stable while writeRequest is high and writeAck is low.
  - writeRequest && writeAck at edge N pops; the next head (or writeRequest=0) appears after edge N.
  - writeAck while writeRequest is low is ignored.
- Latency: a push at edge N into an empty FIFO gives writeRequest=1 after edge N.
- Same-cycle push and pop: fifoLevel is unchanged and ordering is preserved. pixelReady is computed from the registered level and does not anticipate the pop.
- Pointers wrap modulo DEPTH; fifoLevel saturates by construction at DEPTH (no push when full).
- dropped: set when pixelValid && !pixelReady; cleared only by reset. A refused pixel is discarded and the partial word is unaffected.
- Reset asserted mid-operation discards the FIFO contents and the partial word immediately. No write is issued for the discarded data.

Test Plan:
- Pixels (row 2, cols 8,9,10,11), colours 1,2,3,4, consecutive cycles, writeAck tied 1 -> one request: writeAddress=0x202, writeData=0x4321, writeNibbleEn=4'hF, seen one cycle after the col-11 acceptance.
- (row 0, col 5, colour 7) then (row 0, col 20, colour 1) then flush -> word addr 1 data 0x0070 en 4'b0010; word addr 5 data 0x0001 en 4'b0001; in that order.
- writeAck held 0, 40 full words offered with DEPTH=8 -> fifoLevel=8, pixelReady=0, further pixelValid sets dropped=1. Releasing writeAck drains exactly 8 words in order.
- flush while FIFO full with a partial word present -> flushPending holds pixelReady low. One writeAck pops a word; the partial word is pushed on the next edge; pixelReady returns high.
- Same column written twice (colour 3 then 5) then flush -> data nibble=5, single enable bit set.
- rst pulsed low mid-stream with 3 words queued -> writeRequest=0 and fifoLevel=0 asynchronously; no stale word appears after reset release.

Source files
------------

// File: rtl/ddr_pixel_writer.sv
// rtl/ddr_pixel_writer.sv - packs 4-bit pixels into 16-bit words and queues them for DDR writes
//
// Purpose: write-side client for the DDR controller. Per-pixel colour writes are
// merged into a partial 16-bit word (four 4-bit lanes, one per column within a
// group of four). Completed or displaced words go into a small FIFO. The FIFO
// head is offered to the DDR controller over a request/acknowledge handshake.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   pixelValid/Ready  pixel write handshake; pixelRow/Column/Color carry the pixel
//   flush             push the current partial word (deferred while the FIFO is full)
//   writeRequest      FIFO head valid; writeAck pops the head
//   writeAddress/Data/NibbleEn  head word contents (zero while the FIFO is empty)
//   fifoLevel         words currently queued
//   dropped           sticky: a pixel was offered while pixelReady was low
module ddr_pixel_writer #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pixelValid,
  output logic                    pixelReady,
  input  logic [8:0]              pixelRow,
  input  logic [9:0]              pixelColumn,
  input  logic [2:0]              pixelColor,
  input  logic                    flush,
  output logic                    writeRequest,
  input  logic                    writeAck,
  output logic [ADDR_WIDTH-1:0]   writeAddress,
  output logic [15:0]             writeData,
  output logic [3:0]              writeNibbleEn,
  output logic [$clog2(DEPTH):0]  fifoLevel,
  output logic                    dropped
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Partial word being assembled
  logic        part_valid_q, part_valid_d;
  logic [16:0] part_addr_q,  part_addr_d;
  logic [15:0] part_data_q,  part_data_d;
  logic [3:0]  part_en_q,    part_en_d;
  logic        flush_pend_q, flush_pend_d;
  logic        dropped_q,    dropped_d;

  // FIFO storage and pointers
  logic [16:0]      mem_addr [DEPTH];
  logic [15:0]      mem_data [DEPTH];
  logic [3:0]       mem_en   [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q,  level_d;

  // Combinational helpers
  logic [16:0] pix_addr;
  logic [1:0]  lane;
  logic [3:0]  lane_sh;
  logic [15:0] lane_mask;
  logic [15:0] lane_data;
  logic [3:0]  lane_en;
  logic [15:0] merged_data;
  logic [3:0]  merged_en;
  logic        fifo_full;
  logic        fifo_empty;
  logic        accept;
  logic        pop;
  logic        push;
  logic [16:0] push_addr;
  logic [15:0] push_data;
  logic [3:0]  push_en;

  always_comb begin
    pix_addr    = {pixelRow, pixelColumn[9:2]};
    lane        = pixelColumn[1:0];
    lane_sh     = {lane, 2'b00};
    lane_mask   = 16'h000F << lane_sh;
    lane_data   = {13'd0, pixelColor} << lane_sh;
    lane_en     = 4'b0001 << lane;
    merged_data = (part_data_q & ~lane_mask) | lane_data;
    merged_en   = part_en_q | lane_en;

    fifo_full   = (level_q == LVL_W'(DEPTH));
    fifo_empty  = (level_q == '0);
    // Registered level only: a pop in this cycle does not open a slot early.
    pixelReady  = !fifo_full && !flush && !flush_pend_q;
    accept      = pixelValid && pixelReady;
    pop         = !fifo_empty && writeAck;

    push         = 1'b0;
    push_addr    = part_addr_q;
    push_data    = part_data_q;
    push_en      = part_en_q;
    part_valid_d = part_valid_q;
    part_addr_d  = part_addr_q;
    part_data_d  = part_data_q;
    part_en_d    = part_en_q;
    flush_pend_d = flush_pend_q;
    dropped_d    = dropped_q | (pixelValid && !pixelReady);

    if (accept) begin
      if (part_valid_q && (part_addr_q == pix_addr)) begin
        if (lane == 2'd3) begin
          // Lane 3 closes the word: push the merged result directly.
          push         = 1'b1;
          push_data    = merged_data;
          push_en      = merged_en;
          part_valid_d = 1'b0;
        end else begin
          part_data_d = merged_data;
          part_en_d   = merged_en;
        end
      end else begin
        // Different address (or nothing held): the old word leaves as-is and the
        // new pixel starts a fresh partial word, even if it lands in lane 3.
        push         = part_valid_q;
        part_valid_d = 1'b1;
        part_addr_d  = pix_addr;
        part_data_d  = lane_data;
        part_en_d    = lane_en;
      end
    end else if ((flush || flush_pend_q) && part_valid_q) begin
      if (!fifo_full) begin
        push         = 1'b1;
        part_valid_d = 1'b0;
        flush_pend_d = 1'b0;
      end else begin
        flush_pend_d = 1'b1;
      end
    end else if (!part_valid_q) begin
      flush_pend_d = 1'b0;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      part_valid_q <= 1'b0;
      part_addr_q  <= '0;
      part_data_q  <= '0;
      part_en_q    <= '0;
      flush_pend_q <= 1'b0;
      dropped_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
    end else begin
      part_valid_q <= part_valid_d;
      part_addr_q  <= part_addr_d;
      part_data_q  <= part_data_d;
      part_en_q    <= part_en_d;
      flush_pend_q <= flush_pend_d;
      dropped_q    <= dropped_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
    end
  end

  // Storage needs no reset: the head outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_q] <= push_addr;
      mem_data[wr_ptr_q] <= push_data;
      mem_en[wr_ptr_q]   <= push_en;
    end
  end

  assign writeRequest  = !fifo_empty;
  assign writeAddress  = writeRequest ? ADDR_WIDTH'(mem_addr[rd_ptr_q]) : '0;
  assign writeData     = writeRequest ? mem_data[rd_ptr_q] : '0;
  assign writeNibbleEn = writeRequest ? mem_en[rd_ptr_q] : '0;
  assign fifoLevel     = level_q;
  assign dropped       = dropped_q;

endmodule

// File: tb/tb_ddr_pixel_writer.sv
// tb/tb_ddr_pixel_writer.sv - scoreboard bench for ddr_pixel_writer
module tb_ddr_pixel_writer;

  logic        clk;
  logic        rst;
  logic        pixelValid;
  logic        pixelReady;
  logic [8:0]  pixelRow;
  logic [9:0]  pixelColumn;
  logic [2:0]  pixelColor;
  logic        flush;
  logic        writeRequest;
  logic        writeAck;
  logic [22:0] writeAddress;
  logic [15:0] writeData;
  logic [3:0]  writeNibbleEn;
  logic [3:0]  fifoLevel;
  logic        dropped;

  ddr_pixel_writer #(.DEPTH(8), .ADDR_WIDTH(23)) dut (
    .clk(clk), .rst(rst),
    .pixelValid(pixelValid), .pixelReady(pixelReady),
    .pixelRow(pixelRow), .pixelColumn(pixelColumn), .pixelColor(pixelColor),
    .flush(flush),
    .writeRequest(writeRequest), .writeAck(writeAck),
    .writeAddress(writeAddress), .writeData(writeData), .writeNibbleEn(writeNibbleEn),
    .fifoLevel(fifoLevel), .dropped(dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [22:0] addr;
    logic [15:0] data;
    logic [3:0]  en;
  } word_t;

  word_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic expect_word(input logic [22:0] a, input logic [15:0] d, input logic [3:0] e);
    word_t w;
    w.addr = a; w.data = d; w.en = e;
    exp_q.push_back(w);
  endtask

  // Scoreboard: every accepted write (request && ack) must match the queue head.
  always @(negedge clk) begin
    if (rst && writeRequest && writeAck) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {9'd0, writeAddress}, 32'hFFFF_FFFF);
      end else begin
        word_t e;
        e = exp_q.pop_front();
        check("wr_addr", {9'd0, writeAddress}, {9'd0, e.addr});
        check("wr_data", {16'd0, writeData}, {16'd0, e.data});
        check("wr_en",   {28'd0, writeNibbleEn}, {28'd0, e.en});
      end
    end
  end

  task automatic put_pixel(input int r, input int c, input int col);
    int n;
    n = 0;
    @(negedge clk);
    while (!pixelReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!pixelReady) begin
      check("px_ready_timeout", 32'd0, 32'd1);
    end else begin
      pixelRow    = 9'(r);
      pixelColumn = 10'(c);
      pixelColor  = 3'(col);
      pixelValid  = 1'b1;
      @(posedge clk);
      #1 pixelValid = 1'b0;
    end
  endtask

  task automatic pulse_flush();
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check(tag, exp_q.size(), 32'd0);
    check({tag, "_req"}, {31'd0, writeRequest}, 32'd0);
  endtask

  initial begin
    logic [15:0] d;
    rst = 1'b0; pixelValid = 1'b0; pixelRow = '0; pixelColumn = '0; pixelColor = '0;
    flush = 1'b0; writeAck = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req",   {31'd0, writeRequest}, 32'd0);
    check("rst_level", {28'd0, fifoLevel}, 32'd0);
    check("rst_drop",  {31'd0, dropped}, 32'd0);
    check("rst_addr",  {9'd0, writeAddress}, 32'd0);
    check("rst_data",  {16'd0, writeData}, 32'd0);
    check("rst_en",    {28'd0, writeNibbleEn}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 check("idle_ready", {31'd0, pixelReady}, 32'd1);

    // Full word, ack tied high, request one edge after lane 3 acceptance
    writeAck = 1'b1;
    expect_word(23'h202, 16'h4321, 4'hF);
    put_pixel(2, 8, 1);
    put_pixel(2, 9, 2);
    put_pixel(2, 10, 3);
    check("t1_req_before", {31'd0, writeRequest}, 32'd0);
    put_pixel(2, 11, 4);
    check("t1_req_after", {31'd0, writeRequest}, 32'd1);
    wait_drain("t1_drain");

    // Address change pushes old partial word, flush pushes the new one
    expect_word(23'd1, 16'h0070, 4'b0010);
    expect_word(23'd5, 16'h0001, 4'b0001);
    put_pixel(0, 5, 7);
    put_pixel(0, 20, 1);
    pulse_flush();
    wait_drain("t2_drain");
    check("t2_drop", {31'd0, dropped}, 32'd0);

    // Fill with ack low; excess pixels are dropped
    @(posedge clk);
    #1 writeAck = 1'b0;
    for (int w = 0; w < 8; w++) begin
      d = '0;
      for (int l = 0; l < 4; l++) d[4*l +: 4] = 4'((w + l) & 7);
      expect_word({9'd3, 8'(w)}, d, 4'hF);
    end
    for (int w = 0; w < 40; w++) begin
      for (int l = 0; l < 4; l++) begin
        @(negedge clk);
        pixelRow = 9'd3; pixelColumn = 10'(4 * w + l); pixelColor = 3'((w + l) & 7);
        pixelValid = 1'b1;
      end
    end
    @(posedge clk);
    #1 pixelValid = 1'b0;
    check("t3_level", {28'd0, fifoLevel}, 32'd8);
    check("t3_ready", {31'd0, pixelReady}, 32'd0);
    check("t3_drop",  {31'd0, dropped}, 32'd1);
    check("t3_req",   {31'd0, writeRequest}, 32'd1);
    writeAck = 1'b1;
    wait_drain("t3_drain");
    check("t3_level_empty", {28'd0, fifoLevel}, 32'd0);

    // Flush while full with a partial word held
    @(posedge clk);
    #1 writeAck = 1'b0;
    for (int w = 0; w < 7; w++) begin
      expect_word({9'd6, 8'(w)}, 16'h4321, 4'hF);
      for (int l = 0; l < 4; l++) put_pixel(6, 4 * w + l, l + 1);
    end
    expect_word(23'h607, 16'h0222, 4'b0111);
    expect_word(23'h700, 16'h0006, 4'b0001);
    for (int l = 0; l < 3; l++) put_pixel(6, 28 + l, 2);
    put_pixel(7, 0, 6);
    check("t4_full", {28'd0, fifoLevel}, 32'd8);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t4_pend_ready", {31'd0, pixelReady}, 32'd0);
    check("t4_pend_level", {28'd0, fifoLevel}, 32'd8);
    writeAck = 1'b1;
    @(posedge clk);
    #1 writeAck = 1'b0;
    check("t4_pop_level", {28'd0, fifoLevel}, 32'd7);
    check("t4_pop_ready", {31'd0, pixelReady}, 32'd0);
    @(posedge clk);
    #1;
    check("t4_push_level", {28'd0, fifoLevel}, 32'd8);
    writeAck = 1'b1;
    wait_drain("t4_drain");
    check("t4_ready_back", {31'd0, pixelReady}, 32'd1);

    // Rewrite of one lane: last write wins
    expect_word(23'h501, 16'h0500, 4'b0100);
    put_pixel(5, 6, 3);
    put_pixel(5, 6, 5);
    pulse_flush();
    wait_drain("t5_drain");

    // Reset mid-stream discards queued words and the partial word
    @(posedge clk);
    #1 writeAck = 1'b0;
    for (int w = 0; w < 3; w++)
      for (int l = 0; l < 4; l++) put_pixel(8, 4 * w + l, 3);
    put_pixel(9, 0, 2);
    check("t6_level", {28'd0, fifoLevel}, 32'd3);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("t6_rst_req",   {31'd0, writeRequest}, 32'd0);
    check("t6_rst_level", {28'd0, fifoLevel}, 32'd0);
    check("t6_rst_drop",  {31'd0, dropped}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    writeAck = 1'b1;
    pulse_flush();
    repeat (10) @(posedge clk);
    #1;
    check("t6_no_stale_req", {31'd0, writeRequest}, 32'd0);
    check("t6_no_stale_lvl", {28'd0, fifoLevel}, 32'd0);
    check("t6_q_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
